// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue signals of the ALU reservation station.
// The master side is the dispatcher/ALU/CDB environment and the slave side is the station.
interface alu_rs_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int NAME_W = 5,
    parameter int OP_W   = 5
);
    logic              enDisp;
    logic [OP_W-1:0]   dispOp;
    logic [DATA_W-1:0] dispData1;
    logic [TAG_W-1:0]  dispTag1;
    logic [DATA_W-1:0] dispData2;
    logic [TAG_W-1:0]  dispTag2;
    logic [NAME_W-1:0] dispName;
    logic [TAG_W-1:0]  dispTag;
    logic              rsFull;

    logic              enCDBWrt;
    logic [TAG_W-1:0]  CDBwrtTag;
    logic [DATA_W-1:0] CDBwrtData;

    logic              aluReady;
    logic              ALUen;
    logic [OP_W-1:0]   ALUop;
    logic [DATA_W-1:0] ALUsrc1;
    logic [DATA_W-1:0] ALUsrc2;
    logic [NAME_W-1:0] ALUname;
    logic [TAG_W-1:0]  ALUtag;

    modport master (
        output enDisp, dispOp, dispData1, dispTag1, dispData2, dispTag2, dispName, dispTag,
        output enCDBWrt, CDBwrtTag, CDBwrtData, aluReady,
        input  rsFull, ALUen, ALUop, ALUsrc1, ALUsrc2, ALUname, ALUtag
    );

    modport slave (
        input  enDisp, dispOp, dispData1, dispTag1, dispData2, dispTag2, dispName, dispTag,
        input  enCDBWrt, CDBwrtTag, CDBwrtData, aluReady,
        output rsFull, ALUen, ALUop, ALUsrc1, ALUsrc2, ALUname, ALUtag
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are known
// (directly, by dispatch-time CDB bypass, or by CDB wakeup) and issues the lowest ready entry.
module alu_rs #(
    parameter int               RS_SIZE  = 8,
    parameter int               DATA_W   = 32,
    parameter int               TAG_W    = 4,
    parameter int               NAME_W   = 5,
    parameter int               OP_W     = 5,
    parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
    input  logic   clk,
    input  logic   rst,
    alu_rs_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] d1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] d2;
        logic [TAG_W-1:0]  t2;
        logic [NAME_W-1:0] name;
        logic [TAG_W-1:0]  dtag;
    } ent_t;

    localparam ent_t ENT_RST = '{busy: 1'b0, op: '0, d1: '0, t1: TAG_FREE,
                                 d2: '0, t2: TAG_FREE, name: '0, dtag: TAG_FREE};

    ent_t ent_q [RS_SIZE];
    ent_t ent_d [RS_SIZE];
    ent_t disp_ent;

    logic [RS_SIZE-1:0] busy, ready;
    logic [IDX_W-1:0]   iss_idx, free_idx;
    logic               iss_any, full, cdb_hit, do_iss, do_disp, byp1, byp2;

    logic              alu_en_q,   alu_en_d;
    logic [OP_W-1:0]   alu_op_q,   alu_op_d;
    logic [DATA_W-1:0] alu_src1_q, alu_src1_d;
    logic [DATA_W-1:0] alu_src2_q, alu_src2_d;
    logic [NAME_W-1:0] alu_name_q, alu_name_d;
    logic [TAG_W-1:0]  alu_tag_q,  alu_tag_d;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy && (ent_q[i].t1 == TAG_FREE) && (ent_q[i].t2 == TAG_FREE);
        end
    end

    assign full = &busy;

    // Walk downwards so the lowest matching index wins for both selectors.
    always_comb begin
        iss_idx  = '0;
        iss_any  = 1'b0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                iss_idx = IDX_W'(i);
                iss_any = 1'b1;
            end
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    assign cdb_hit = bus.enCDBWrt && (bus.CDBwrtTag != TAG_FREE);
    assign do_iss  = bus.aluReady && iss_any;
    assign do_disp = bus.enDisp && !full;
    assign byp1    = cdb_hit && (bus.dispTag1 == bus.CDBwrtTag);
    assign byp2    = cdb_hit && (bus.dispTag2 == bus.CDBwrtTag);

    always_comb begin
        disp_ent      = ENT_RST;
        disp_ent.busy = 1'b1;
        disp_ent.op   = bus.dispOp;
        disp_ent.d1   = byp1 ? bus.CDBwrtData : bus.dispData1;
        disp_ent.t1   = byp1 ? TAG_FREE : bus.dispTag1;
        disp_ent.d2   = byp2 ? bus.CDBwrtData : bus.dispData2;
        disp_ent.t2   = byp2 ? TAG_FREE : bus.dispTag2;
        disp_ent.name = bus.dispName;
        disp_ent.dtag = bus.dispTag;
    end

    // Allocation looks only at pre-edge busy bits, so a slot freed by issue stays empty this cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && cdb_hit) begin
                if (ent_q[i].t1 == bus.CDBwrtTag) begin
                    ent_d[i].d1 = bus.CDBwrtData;
                    ent_d[i].t1 = TAG_FREE;
                end
                if (ent_q[i].t2 == bus.CDBwrtTag) begin
                    ent_d[i].d2 = bus.CDBwrtData;
                    ent_d[i].t2 = TAG_FREE;
                end
            end
            if (do_iss && (iss_idx == IDX_W'(i))) ent_d[i].busy = 1'b0;
            if (do_disp && (free_idx == IDX_W'(i))) ent_d[i] = disp_ent;
        end
    end

    always_comb begin
        alu_en_d   = 1'b0;
        alu_op_d   = alu_op_q;
        alu_src1_d = alu_src1_q;
        alu_src2_d = alu_src2_q;
        alu_name_d = alu_name_q;
        alu_tag_d  = alu_tag_q;
        if (do_iss) begin
            alu_en_d   = 1'b1;
            alu_op_d   = ent_q[iss_idx].op;
            alu_src1_d = ent_q[iss_idx].d1;
            alu_src2_d = ent_q[iss_idx].d2;
            alu_name_d = ent_q[iss_idx].name;
            alu_tag_d  = ent_q[iss_idx].dtag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ENT_RST;
            alu_en_q   <= 1'b0;
            alu_op_q   <= '0;
            alu_src1_q <= '0;
            alu_src2_q <= '0;
            alu_name_q <= '0;
            alu_tag_q  <= TAG_FREE;
        end else begin
            ent_q      <= ent_d;
            alu_en_q   <= alu_en_d;
            alu_op_q   <= alu_op_d;
            alu_src1_q <= alu_src1_d;
            alu_src2_q <= alu_src2_d;
            alu_name_q <= alu_name_d;
            alu_tag_q  <= alu_tag_d;
        end
    end

    assign bus.rsFull  = full;
    assign bus.ALUen   = alu_en_q;
    assign bus.ALUop   = alu_op_q;
    assign bus.ALUsrc1 = alu_src1_q;
    assign bus.ALUsrc2 = alu_src2_q;
    assign bus.ALUname = alu_name_q;
    assign bus.ALUtag  = alu_tag_q;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed vector table, hand sequences for fill/drain, wakeup order
// and reset, then random traffic against an array-based model of the station.
module tb_alu_rs;
    localparam int RS_SIZE = 8;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int NAME_W  = 5;
    localparam int OP_W    = 5;
    localparam int NRAND   = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_rs_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NAME_W(NAME_W), .OP_W(OP_W)) bus();

    alu_rs #(.RS_SIZE(RS_SIZE), .DATA_W(DATA_W), .TAG_W(TAG_W), .NAME_W(NAME_W),
             .OP_W(OP_W), .TAG_FREE('0)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned en_d, op, d1, t1, d2, t2, name, dtag;
        int unsigned en_c, ctag, cdata;
        int unsigned x_en, x_op, x_s1, x_s2, x_name, x_tag, x_full;
    } vec_t;
    vec_t tv [15];

    typedef struct {
        bit          busy;
        int unsigned op, d1, t1, d2, t2, name, dtag;
    } ment_t;
    ment_t       m [RS_SIZE];
    bit          m_en;
    int unsigned m_op, m_s1, m_s2, m_name, m_tag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.enDisp     = 1'b0;
        bus.dispOp     = '0;
        bus.dispData1  = '0;
        bus.dispTag1   = '0;
        bus.dispData2  = '0;
        bus.dispTag2   = '0;
        bus.dispName   = '0;
        bus.dispTag    = '0;
        bus.enCDBWrt   = 1'b0;
        bus.CDBwrtTag  = '0;
        bus.CDBwrtData = '0;
    endtask

    task automatic disp(input int unsigned op, d1, t1, d2, t2, name, dtag);
        bus.enDisp    = 1'b1;
        bus.dispOp    = OP_W'(op);
        bus.dispData1 = DATA_W'(d1);
        bus.dispTag1  = TAG_W'(t1);
        bus.dispData2 = DATA_W'(d2);
        bus.dispTag2  = TAG_W'(t2);
        bus.dispName  = NAME_W'(name);
        bus.dispTag   = TAG_W'(dtag);
    endtask

    task automatic cdb(input int unsigned tag, data);
        bus.enCDBWrt   = 1'b1;
        bus.CDBwrtTag  = TAG_W'(tag);
        bus.CDBwrtData = DATA_W'(data);
    endtask

    task automatic chk_out(input string nm, input int unsigned en, tag, s1, s2);
        chk({nm, "_en"},  64'(bus.ALUen),   64'(en));
        chk({nm, "_tag"}, 64'(bus.ALUtag),  64'(tag));
        chk({nm, "_s1"},  64'(bus.ALUsrc1), 64'(s1));
        chk({nm, "_s2"},  64'(bus.ALUsrc2), 64'(s2));
    endtask

    // Model step for one edge: pre-edge issue pick and free slot, then wakeup, issue clear and allocation.
    task automatic model_step(input bit de, input int unsigned op, d1, t1, d2, t2, name, dtag,
                              input bit ce, input int unsigned ct, cd, input bit rdy);
        int iss = -1;
        int fr  = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m[i].busy && m[i].t1 == 0 && m[i].t2 == 0) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        m_en = 1'b0;
        if (rdy && iss >= 0) begin
            m_en = 1'b1;
            m_op = m[iss].op; m_s1 = m[iss].d1; m_s2 = m[iss].d2;
            m_name = m[iss].name; m_tag = m[iss].dtag;
            m[iss].busy = 1'b0;
        end
        if (ce && ct != 0) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (m[i].busy && m[i].t1 == ct) begin m[i].d1 = cd; m[i].t1 = 0; end
                if (m[i].busy && m[i].t2 == ct) begin m[i].d2 = cd; m[i].t2 = 0; end
            end
        end
        if (de && fr >= 0) begin
            m[fr].busy = 1'b1;
            m[fr].op = op; m[fr].name = name; m[fr].dtag = dtag;
            if (ce && ct != 0 && t1 == ct) begin m[fr].d1 = cd; m[fr].t1 = 0; end
            else begin m[fr].d1 = d1; m[fr].t1 = t1; end
            if (ce && ct != 0 && t2 == ct) begin m[fr].d2 = cd; m[fr].t2 = 0; end
            else begin m[fr].d2 = d2; m[fr].t2 = t2; end
        end
    endtask

    initial begin
        int unsigned r_de, r_op, r_d1, r_t1, r_d2, r_t2, r_nm, r_dt, r_ce, r_ct, r_cd, r_rdy, nb;

        //       en_d op d1     t1 d2    t2 nm dt en_c ct cdata   x_en op s1      s2    nm tag full
        tv[0]  = '{1, 3, 5,      0, 7,    0, 2, 1, 0, 0, 0,      0, 0, 0,      0,    0, 0, 0};
        tv[1]  = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      1, 3, 5,      7,    2, 1, 0};
        tv[2]  = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      0, 3, 5,      7,    2, 1, 0};
        tv[3]  = '{1, 1, 'hAA,   3, 9,    0, 4, 2, 0, 0, 0,      0, 3, 5,      7,    2, 1, 0};
        tv[4]  = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      0, 3, 5,      7,    2, 1, 0};
        tv[5]  = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      0, 3, 5,      7,    2, 1, 0};
        tv[6]  = '{0, 0, 0,      0, 0,    0, 0, 0, 1, 3, 'hDEAD, 0, 3, 5,      7,    2, 1, 0};
        tv[7]  = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      1, 1, 'hDEAD, 9,    4, 2, 0};
        tv[8]  = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      0, 1, 'hDEAD, 9,    4, 2, 0};
        tv[9]  = '{1, 2, 0,      4, 'h22, 0, 5, 3, 1, 4, 'h11,   0, 1, 'hDEAD, 9,    4, 2, 0};
        tv[10] = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      1, 2, 'h11,   'h22, 5, 3, 0};
        tv[11] = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      0, 2, 'h11,   'h22, 5, 3, 0};
        tv[12] = '{1, 6, 1,      7, 2,    7, 6, 4, 1, 7, 'h55,   0, 2, 'h11,   'h22, 5, 3, 0};
        tv[13] = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      1, 6, 'h55,   'h55, 6, 4, 0};
        tv[14] = '{0, 0, 0,      0, 0,    0, 0, 0, 0, 0, 0,      0, 6, 'h55,   'h55, 6, 4, 0};

        clr();
        bus.aluReady = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset_full", 64'(bus.rsFull), 64'(0));
        chk("reset_op",   64'(bus.ALUop),  64'(0));

        bus.aluReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (tv[i].en_d != 0) disp(tv[i].op, tv[i].d1, tv[i].t1, tv[i].d2, tv[i].t2, tv[i].name, tv[i].dtag);
            if (tv[i].en_c != 0) cdb(tv[i].ctag, tv[i].cdata);
            tick();
            clr();
            chk_out($sformatf("vec%0d", i), tv[i].x_en, tv[i].x_tag, tv[i].x_s1, tv[i].x_s2);
            chk($sformatf("vec%0d_op", i),   64'(bus.ALUop),   64'(tv[i].x_op));
            chk($sformatf("vec%0d_name", i), 64'(bus.ALUname), 64'(tv[i].x_name));
            chk($sformatf("vec%0d_full", i), 64'(bus.rsFull),  64'(tv[i].x_full));
        end

        // Fill with the ALU stalled, drop the overflow, then drain in index order.
        bus.aluReady = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(i, 'h100 + i, 0, 'h200 + i, 0, i, 8 + i);
            tick();
            clr();
            chk($sformatf("fill%0d_full", i), 64'(bus.rsFull), 64'(i == RS_SIZE - 1));
        end
        disp(1, 1, 0, 1, 0, 1, 3);
        tick();
        clr();
        chk("drop_full", 64'(bus.rsFull), 64'(1));
        chk("drop_en",   64'(bus.ALUen),  64'(0));
        bus.aluReady = 1'b1;
        disp(1, 1, 0, 1, 0, 1, 5);
        tick();
        clr();
        chk_out("drain0", 1, 8, 'h100, 'h200);
        chk("drain0_full", 64'(bus.rsFull), 64'(0));
        for (int k = 1; k < RS_SIZE; k++) begin
            tick();
            chk_out($sformatf("drain%0d", k), 1, 8 + k, 'h100 + k, 'h200 + k);
        end
        tick();
        chk("drain_end_en", 64'(bus.ALUen), 64'(0));

        // Out-of-order wakeup; a TAG_FREE broadcast must not touch anything.
        disp(9, 0, 5, 'h20, 0, 1, 1);
        tick(); clr();
        disp(10, 'h10, 0, 0, 6, 2, 2);
        tick(); clr();
        cdb(0, 'hBAD);
        tick(); clr();
        chk("free_bcast_en0", 64'(bus.ALUen), 64'(0));
        tick();
        chk("free_bcast_en1", 64'(bus.ALUen), 64'(0));
        cdb(6, 'h66);
        tick(); clr();
        chk("wake6_en", 64'(bus.ALUen), 64'(0));
        cdb(5, 'h55);
        tick(); clr();
        chk_out("ooo_first", 1, 2, 'h10, 'h66);
        tick();
        chk_out("ooo_second", 1, 1, 'h55, 'h20);
        tick();
        chk("ooo_end_en", 64'(bus.ALUen), 64'(0));

        // Reset with live entries, an active issue and a pending wakeup.
        bus.aluReady = 1'b0;
        disp(1, 1, 0, 1, 0, 1, 1); tick(); clr();
        disp(2, 2, 0, 2, 0, 2, 2); tick(); clr();
        disp(3, 3, 0, 3, 0, 3, 3); tick(); clr();
        disp(4, 4, 9, 4, 0, 4, 4); tick(); clr();
        bus.aluReady = 1'b1;
        tick();
        chk_out("pre_rst", 1, 1, 1, 1);
        rst = 1'b1;
        cdb(9, 'h99);
        disp(7, 7, 0, 7, 0, 7, 7);
        tick();
        rst = 1'b0;
        clr();
        chk_out("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_full", 64'(bus.rsFull), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d_en", k), 64'(bus.ALUen), 64'(0));
        end

        // Random traffic against the model, starting from the empty post-reset state.
        for (int i = 0; i < RS_SIZE; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
        m_en = 1'b0; m_op = 0; m_s1 = 0; m_s2 = 0; m_name = 0; m_tag = 0;
        for (int c = 0; c < NRAND; c++) begin
            r_de  = ($urandom_range(0, 9) < 6) ? 1 : 0;
            r_op  = $urandom_range(0, 31);
            r_d1  = $urandom;
            r_t1  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 15);
            r_d2  = $urandom;
            r_t2  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 15);
            r_nm  = $urandom_range(0, 31);
            r_dt  = $urandom_range(1, 15);
            r_ce  = $urandom_range(0, 1);
            r_ct  = $urandom_range(0, 15);
            r_cd  = $urandom;
            r_rdy = ($urandom_range(0, 9) < 7) ? 1 : 0;
            if (r_de != 0) disp(r_op, r_d1, r_t1, r_d2, r_t2, r_nm, r_dt);
            if (r_ce != 0) cdb(r_ct, r_cd);
            bus.aluReady = r_rdy[0];
            nb = 0;
            for (int i = 0; i < RS_SIZE; i++) nb += m[i].busy;
            chk("rand_full", 64'(bus.rsFull), 64'(nb == RS_SIZE));
            model_step(r_de[0], r_op, r_d1, r_t1, r_d2, r_t2, r_nm, r_dt, r_ce[0], r_ct, r_cd, r_rdy[0]);
            tick();
            clr();
            chk_out("rand", m_en, m_tag, m_s1, m_s2);
            chk("rand_op",   64'(bus.ALUop),   64'(m_op));
            chk("rand_name", 64'(bus.ALUname), 64'(m_name));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
